// File: rtl/bus_decoder.sv
// 1-master / N-slave memory bus decoder: registered request forwarding, error response
// for unmapped addresses, optional slave timeout enabled by the BUS_TIMEOUT_EN macro.
module bus_decoder #(
    parameter int                          N_SLV     = 5,
    parameter int                          ADDR_W    = 16,
    parameter int                          DATA_W    = 16,
    parameter logic [N_SLV*ADDR_W-1:0]     SLV_BASE  = {16'hB000, 16'h8200, 16'h8100, 16'h8000, 16'h0000},
    parameter logic [N_SLV*(ADDR_W+1)-1:0] SLV_SIZE  = {17'h05000, 17'h00100, 17'h00100, 17'h00001, 17'h08000},
    parameter logic [DATA_W-1:0]           ERR_RDATA = 16'hDEAD,
    parameter int                          TIMEOUT   = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_mem_valid,
    input  logic [DATA_W/8-1:0]        i_mem_wstrb,
    input  logic [ADDR_W-1:0]          i_mem_addr,
    input  logic [DATA_W-1:0]          i_mem_wdata,
    output logic                       o_mem_ready,
    output logic [DATA_W-1:0]          o_mem_rdata,
    output logic [N_SLV-1:0]           o_s_valid,
    output logic [N_SLV*DATA_W/8-1:0]  o_s_wstrb,
    output logic [N_SLV*ADDR_W-1:0]    o_s_addr,
    output logic [N_SLV*DATA_W-1:0]    o_s_wdata,
    input  logic [N_SLV-1:0]           i_s_ready,
    input  logic [N_SLV*DATA_W-1:0]    i_s_rdata,
    output logic                       o_bus_err,
    output logic [ADDR_W-1:0]          o_err_addr
);
    localparam int SW    = DATA_W / 8;
    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [N_SLV-1:0]    r_s_valid;
    logic [SW-1:0]       r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_mem_ready;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_bus_err;
    logic [ADDR_W-1:0]   r_err_addr;
`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_req_addr;
`endif

    logic [N_SLV-1:0]    w_hit_vec;
    logic [ADDR_W-1:0]   w_offs [N_SLV];
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic [ADDR_W-1:0]   w_off;
    logic [DATA_W-1:0]   w_sel_rdata;

    // Window compare is done in ADDR_W+1 bits so a window may end exactly at 2^ADDR_W.
    for (genvar g = 0; g < N_SLV; g++) begin : g_slv
        logic [ADDR_W:0] w_base;
        logic [ADDR_W:0] w_end;
        assign w_base       = {1'b0, SLV_BASE[g*ADDR_W +: ADDR_W]};
        assign w_end        = w_base + SLV_SIZE[g*(ADDR_W+1) +: ADDR_W+1];
        assign w_hit_vec[g] = ({1'b0, i_mem_addr} >= w_base) && ({1'b0, i_mem_addr} < w_end);
        assign w_offs[g]    = i_mem_addr - SLV_BASE[g*ADDR_W +: ADDR_W];

        assign o_s_valid[g]                  = r_s_valid[g];
        assign o_s_wstrb[g*SW +: SW]         = r_s_valid[g] ? r_wstrb : '0;
        assign o_s_addr[g*ADDR_W +: ADDR_W]  = r_s_valid[g] ? r_addr  : '0;
        assign o_s_wdata[g*DATA_W +: DATA_W] = r_s_valid[g] ? r_wdata : '0;
    end

    assign w_hit = |w_hit_vec;

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_idx = '0;
        w_off = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_idx = IDX_W'(i);
                w_off = w_offs[i];
            end
        end
    end

    assign w_sel_rdata = i_s_rdata[r_idx*DATA_W +: DATA_W];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_s_valid   <= '0;
            r_wstrb     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_ready <= 1'b0;
            r_rdata     <= '0;
            r_bus_err   <= 1'b0;
            r_err_addr  <= '0;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= '0;
            r_req_addr  <= '0;
`endif
        end else begin
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mem_valid) begin
                        if (w_hit) begin
                            r_idx     <= w_idx;
                            r_s_valid <= N_SLV'(1) << w_idx;
                            r_addr    <= w_off;
                            r_wstrb   <= i_mem_wstrb;
                            r_wdata   <= i_mem_wdata;
                            r_state   <= S_ACCESS;
`ifdef BUS_TIMEOUT_EN
                            r_cnt      <= '0;
                            r_req_addr <= i_mem_addr;
`endif
                        end else begin
                            r_mem_ready <= 1'b1;
                            r_bus_err   <= 1'b1;
                            r_rdata     <= ERR_RDATA;
                            r_err_addr  <= i_mem_addr;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (i_s_ready[r_idx]) begin
                        r_s_valid   <= '0;
                        r_rdata     <= (|r_wstrb) ? '0 : w_sel_rdata;
                        r_mem_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_s_valid   <= '0;
                        r_rdata     <= ERR_RDATA;
                        r_mem_ready <= 1'b1;
                        r_bus_err   <= 1'b1;
                        r_err_addr  <= r_req_addr;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_rdata <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_ready = r_mem_ready;
    assign o_mem_rdata = r_rdata;
    assign o_bus_err   = r_bus_err;
    assign o_err_addr  = r_err_addr;

endmodule

// File: tb/tb_bus_decoder.sv
// Scoreboard bench for bus_decoder on the 5-slave test map; the timeout scenario
// is included when BUS_TIMEOUT_EN is defined.
module tb_bus_decoder;
    localparam int N = 5, AW = 16, DW = 16, SW = 2;
    localparam int NEVER = 100000;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_valid;
    logic [SW-1:0]   mem_wstrb;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;
    logic [N-1:0]    s_valid;
    logic [N*SW-1:0] s_wstrb;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N-1:0]    s_ready;
    logic [N*DW-1:0] s_rdata;
    logic            bus_err;
    logic [AW-1:0]   err_addr;

    bus_decoder #(.TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_mem_valid(mem_valid), .i_mem_wstrb(mem_wstrb),
        .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata), .o_mem_ready(mem_ready),
        .o_mem_rdata(mem_rdata), .o_s_valid(s_valid), .o_s_wstrb(s_wstrb),
        .o_s_addr(s_addr), .o_s_wdata(s_wdata), .i_s_ready(s_ready),
        .i_s_rdata(s_rdata), .o_bus_err(bus_err), .o_err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Slave model: slave i raises s_ready on ACCESS cycle slv_delay[i]+1.
    int            acc_cnt   [N];
    int            slv_delay [N];
    logic [DW-1:0] slv_rdata [N];
    logic [N-1:0]  stray;

    always @(posedge clk)
        for (int i = 0; i < N; i++) acc_cnt[i] <= s_valid[i] ? acc_cnt[i] + 1 : 0;

    always_comb begin
        s_ready = stray;
        s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (s_valid[i] && acc_cnt[i] == slv_delay[i]) s_ready[i] = 1'b1;
            s_rdata[i*DW +: DW] = slv_rdata[i];
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (!rst && mem_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready rdata=%h bus_err=%b", mem_rdata, bus_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (mem_rdata !== e.rdata || bus_err !== e.err) begin
                    errors++;
                    $display("FAIL response got rdata=%h err=%b exp rdata=%h err=%b",
                             mem_rdata, bus_err, e.rdata, e.err);
                end
            end
        end
        if (!rst && bus_err && !mem_ready) begin
            checks++;
            errors++;
            $display("FAIL bus_err_without_ready got=1 exp=0");
        end
    end

    // Observations from the most recent transaction
    int              lat, sv_cycles;
    logic [N-1:0]    sv_seen;
    logic [N*AW-1:0] seen_addr;
    logic [N*DW-1:0] seen_wdata;
    logic [N*SW-1:0] seen_wstrb;

    task automatic do_txn(input logic [AW-1:0] a, input logic [SW-1:0] ws,
                          input logic [DW-1:0] wd, input logic [DW-1:0] er, input logic ee);
        exp_t e;
        bit got;
        e.rdata = er;
        e.err   = ee;
        q.push_back(e);
        mem_valid = 1'b1; mem_addr = a; mem_wstrb = ws; mem_wdata = wd;
        lat = 0; sv_cycles = 0; sv_seen = '0; got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (s_valid != '0) begin
                if (sv_seen == '0) begin
                    sv_seen = s_valid; seen_addr = s_addr; seen_wdata = s_wdata; seen_wstrb = s_wstrb;
                end
                sv_cycles++;
            end
            if (mem_ready) got = 1;
        end
        mem_valid = 1'b0; mem_wstrb = '0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_no_ready addr=%h got no mem_ready within 300 cycles", a);
            q.delete(q.size() - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_valid, s_wstrb, s_addr, s_wdata, mem_ready, mem_rdata, bus_err, err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs s_valid=%b mem_ready=%b rdata=%h err=%b err_addr=%h exp all 0",
                     s_valid, mem_ready, mem_rdata, bus_err, err_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        do_txn(16'h9000, 2'b00, 16'h0, 16'hDEAD, 1'b1);
        @(negedge clk);
        checks++;
        if (err_addr !== 16'h9000) begin
            errors++; $display("FAIL err_addr_pre_reset got=%h exp=9000", err_addr);
        end
        // Slave 0 never answers; reset lands mid-ACCESS
        slv_delay[0] = NEVER;
        mem_valid = 1'b1; mem_addr = 16'h0010; mem_wstrb = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (s_valid !== 5'b00001) begin
            errors++; $display("FAIL access_before_reset s_valid got=%b exp=00001", s_valid);
        end
        rst = 1'b1; mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_valid, s_wstrb, s_addr, s_wdata, mem_ready, mem_rdata, bus_err, err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_traffic s_valid=%b mem_ready=%b rdata=%h err=%b err_addr=%h exp all 0",
                     s_valid, mem_ready, mem_rdata, bus_err, err_addr);
        end
        rst = 1'b0;
        slv_delay[0] = 0;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [N*AW-1:0] ea;
        @(negedge clk);
        slv_delay[2] = 2; slv_rdata[2] = 16'hBEEF;
        stray = 5'b00001;
        do_txn(16'h8104, 2'b00, 16'h0, 16'hBEEF, 1'b0);
        stray = '0;
        ea = '0; ea[2*AW +: AW] = 16'h0004;
        checks++;
        if (sv_seen !== 5'b00100 || seen_addr !== ea) begin
            errors++; $display("FAIL read_select s_valid=%b s_addr=%h exp 00100 / %h", sv_seen, seen_addr, ea);
        end
        checks++;
        if (lat !== 4 || sv_cycles !== 3) begin
            errors++; $display("FAIL read_latency lat=%0d sv_cycles=%0d exp 4 / 3", lat, sv_cycles);
        end
    endtask

    task automatic test_write();
        logic [N*AW-1:0] ea;
        logic [N*DW-1:0] ed;
        logic [N*SW-1:0] es;
        @(negedge clk);
        slv_delay[1] = 0; slv_rdata[1] = 16'h1234;
        do_txn(16'h8000, 2'b01, 16'h000F, 16'h0000, 1'b0);
        ea = '0; ed = '0; ed[1*DW +: DW] = 16'h000F; es = '0; es[1*SW +: SW] = 2'b01;
        checks++;
        if (sv_seen !== 5'b00010 || seen_addr !== ea || seen_wdata !== ed || seen_wstrb !== es) begin
            errors++;
            $display("FAIL write_fields s_valid=%b addr=%h wdata=%h wstrb=%b exp 00010 / %h / %h / %b",
                     sv_seen, seen_addr, seen_wdata, seen_wstrb, ea, ed, es);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL write_latency got=%0d exp=2", lat);
        end
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        do_txn(16'hA000, 2'b00, 16'h0, 16'hDEAD, 1'b1);
        checks++;
        if (sv_seen !== '0 || lat !== 1) begin
            errors++; $display("FAIL unmapped_path s_valid=%b lat=%0d exp 00000 / 1", sv_seen, lat);
        end
        checks++;
        if (err_addr !== 16'hA000) begin
            errors++; $display("FAIL unmapped_err_addr got=%h exp=A000", err_addr);
        end
    endtask

    task automatic test_boundary();
        logic [N*AW-1:0] ea;
        @(negedge clk);
        slv_delay[4] = 1; slv_rdata[4] = 16'h4444;
        do_txn(16'hFFFF, 2'b00, 16'h0, 16'h4444, 1'b0);
        ea = '0; ea[4*AW +: AW] = 16'h4FFF;
        checks++;
        if (sv_seen !== 5'b10000 || seen_addr !== ea) begin
            errors++; $display("FAIL top_window s_valid=%b s_addr=%h exp 10000 / %h", sv_seen, seen_addr, ea);
        end
        @(negedge clk);
        do_txn(16'h8300, 2'b00, 16'h0, 16'hDEAD, 1'b1);
        checks++;
        if (sv_seen !== '0 || lat !== 1 || err_addr !== 16'h8300) begin
            errors++;
            $display("FAIL gap_miss s_valid=%b lat=%0d err_addr=%h exp 00000 / 1 / 8300", sv_seen, lat, err_addr);
        end
    endtask

    // Addresses with independently derived slave index (-1 = unmapped) and offset
    typedef struct {
        logic [AW-1:0] a;
        int            slv;
        logic [AW-1:0] off;
    } map_t;

    task automatic test_back_to_back();
        map_t tbl[12];
        tbl[0]  = '{16'h0000, 0, 16'h0000};  tbl[1]  = '{16'h7FFF, 0, 16'h7FFF};
        tbl[2]  = '{16'h8000, 1, 16'h0000};  tbl[3]  = '{16'h8001, -1, 16'h0000};
        tbl[4]  = '{16'h8100, 2, 16'h0000};  tbl[5]  = '{16'h81FF, 2, 16'h00FF};
        tbl[6]  = '{16'h8200, 3, 16'h0000};  tbl[7]  = '{16'h82FF, 3, 16'h00FF};
        tbl[8]  = '{16'h8300, -1, 16'h0000}; tbl[9]  = '{16'hAFFF, -1, 16'h0000};
        tbl[10] = '{16'hB000, 4, 16'h0000};  tbl[11] = '{16'hFFFF, 4, 16'h4FFF};
        for (int i = 0; i < N; i++) begin
            slv_delay[i] = $urandom_range(0, 3);
            slv_rdata[i] = 16'($urandom);
        end
        for (int t = 0; t < 24; t++) begin
            int k;
            logic [SW-1:0] ws;
            logic [DW-1:0] wd, er;
            logic [N-1:0]  esv;
            logic [N*AW-1:0] ea;
            k  = $urandom_range(0, 11);
            ws = SW'($urandom_range(0, 3));
            wd = 16'($urandom);
            if (tbl[k].slv < 0) er = 16'hDEAD;
            else if (ws != '0) er = 16'h0000;
            else er = slv_rdata[tbl[k].slv];
            do_txn(tbl[k].a, ws, wd, er, tbl[k].slv < 0);
            esv = '0; ea = '0;
            if (tbl[k].slv >= 0) begin
                esv[tbl[k].slv] = 1'b1;
                ea[tbl[k].slv*AW +: AW] = tbl[k].off;
            end
            checks++;
            if (sv_seen !== esv || seen_addr !== ea) begin
                errors++;
                $display("FAIL b2b_decode addr=%h s_valid=%b s_addr=%h exp %b / %h",
                         tbl[k].a, sv_seen, seen_addr, esv, ea);
            end
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        slv_delay[0] = NEVER;
        do_txn(16'h0020, 2'b00, 16'h0, 16'hDEAD, 1'b1);
        checks++;
        if (sv_cycles !== 8 || err_addr !== 16'h0020) begin
            errors++; $display("FAIL timeout sv_cycles=%0d err_addr=%h exp 8 / 0020", sv_cycles, err_addr);
        end
        slv_delay[0] = 0;
        slv_delay[2] = 0; slv_rdata[2] = 16'hBEEF;
        @(negedge clk);
        do_txn(16'h8104, 2'b00, 16'h0, 16'hBEEF, 1'b0);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL after_timeout lat=%0d exp=2", lat);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_valid = 1'b0; mem_wstrb = '0; mem_addr = '0; mem_wdata = '0;
        stray = '0;
        for (int i = 0; i < N; i++) begin
            slv_delay[i] = 0;
            slv_rdata[i] = 16'h0;
        end
        @(negedge clk);
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_boundary();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain pending=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
